// File: rtl/data_mem_responder.sv
// Data-memory responder for the core: combinational loads, synchronous stores,
// a four-phase debug read port, a saturating store counter and a sticky range error.
module data_mem_responder #(
  parameter int ADDR_BITS = 8,
  parameter int DATA_W    = 16
) (
  input  logic                 clk,
  input  logic                 r_st,
  input  logic [15:0]          d_addr,
  input  logic                 d_we,
  input  logic [DATA_W-1:0]    d_wdata,
  output logic [DATA_W-1:0]    d_dataout,
  input  logic                 dbg_req,
  input  logic [ADDR_BITS-1:0] dbg_addr,
  output logic                 dbg_ack,
  output logic [DATA_W-1:0]    dbg_rdata,
  output logic [15:0]          st_count,
  output logic                 addr_err
);

  localparam int DEPTH = 1 << ADDR_BITS;

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_ACK,
    S_WAIT
  } dbg_state_t;

  logic [DATA_W-1:0]    r_mem [DEPTH];
  dbg_state_t           r_state;
  logic [ADDR_BITS-1:0] r_a_q;
  logic                 r_dbg_ack;
  logic [DATA_W-1:0]    r_dbg_rdata;
  logic [15:0]          r_st_count;
  logic                 r_addr_err;

  logic                 w_in_range;
  logic [ADDR_BITS-1:0] w_idx;
  logic                 w_store;
  logic                 w_bad_store;

  assign w_in_range  = (d_addr >> ADDR_BITS) == 16'h0000;
  assign w_idx       = d_addr[ADDR_BITS-1:0];
  assign w_store     = d_we & w_in_range;
  assign w_bad_store = d_we & ~w_in_range;

  // Loads see the pre-edge contents, so a same-cycle store is not forwarded.
  assign d_dataout = w_in_range ? r_mem[w_idx] : '0;

  // NOTE: every word is cleared by the asynchronous reset, which forces this
  // array into flops; an SRAM macro could not honour that reset.
  always_ff @(posedge clk or posedge r_st) begin
    if (r_st) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_store) begin
      r_mem[w_idx] <= d_wdata;
    end
  end

  always_ff @(posedge clk or posedge r_st) begin
    if (r_st) begin
      r_st_count <= 16'h0000;
      r_addr_err <= 1'b0;
    end else begin
      if (w_store && r_st_count != 16'hFFFF) begin
        r_st_count <= r_st_count + 16'd1;
      end
      if (w_bad_store) begin
        r_addr_err <= 1'b1;
      end
    end
  end

  // Debug handshake; a request still high after ack only releases from WAIT.
  always_ff @(posedge clk or posedge r_st) begin
    if (r_st) begin
      r_state     <= S_IDLE;
      r_a_q       <= '0;
      r_dbg_ack   <= 1'b0;
      r_dbg_rdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (dbg_req) begin
            r_a_q   <= dbg_addr;
            r_state <= S_READ;
          end
        end
        S_READ: begin
          // A core store landing on this edge wins, so the host sees new data.
          if (w_store && w_idx == r_a_q) begin
            r_dbg_rdata <= d_wdata;
          end else begin
            r_dbg_rdata <= r_mem[r_a_q];
          end
          r_state <= S_ACK;
        end
        S_ACK: begin
          r_dbg_ack <= 1'b1;
          r_state   <= S_WAIT;
        end
        S_WAIT: begin
          if (!dbg_req) begin
            r_dbg_ack <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        default: begin
          r_dbg_ack <= 1'b0;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

  assign dbg_ack   = r_dbg_ack;
  assign dbg_rdata = r_dbg_rdata;
  assign st_count  = r_st_count;
  assign addr_err  = r_addr_err;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: a word-level model feeds a scoreboard
// queue of expected load/debug data, popped when the DUT output is sampled.
module tb_data_mem_responder;

  localparam int ADDR_BITS = 8;
  localparam int DEPTH     = 1 << ADDR_BITS;

  logic                 clk = 1'b0;
  logic                 r_st;
  logic [15:0]          d_addr;
  logic                 d_we;
  logic [15:0]          d_wdata;
  logic [15:0]          d_dataout;
  logic                 dbg_req;
  logic [ADDR_BITS-1:0] dbg_addr;
  logic                 dbg_ack;
  logic [15:0]          dbg_rdata;
  logic [15:0]          st_count;
  logic                 addr_err;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [15:0] model_mem [DEPTH];
  logic [15:0] model_cnt;
  logic        model_err;
  logic [15:0] exp_q [$];

  data_mem_responder #(.ADDR_BITS(ADDR_BITS), .DATA_W(16)) dut (
    .clk       (clk),
    .r_st      (r_st),
    .d_addr    (d_addr),
    .d_we      (d_we),
    .d_wdata   (d_wdata),
    .d_dataout (d_dataout),
    .dbg_req   (dbg_req),
    .dbg_addr  (dbg_addr),
    .dbg_ack   (dbg_ack),
    .dbg_rdata (dbg_rdata),
    .st_count  (st_count),
    .addr_err  (addr_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_pop(input string tag, input logic [15:0] obs);
    logic [15:0] e;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_fail++;
      $error("FAIL %s: scoreboard empty, observed %h", tag, obs);
    end else begin
      e = exp_q.pop_front();
      check(tag, obs, e);
    end
  endtask

  function automatic logic in_rng(input logic [15:0] a);
    return a[15:ADDR_BITS] == '0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 16'h0000;
    model_cnt = 16'h0000;
    model_err = 1'b0;
  endtask

  task automatic model_store(input logic [15:0] a, input logic [15:0] w);
    if (in_rng(a)) begin
      model_mem[a[ADDR_BITS-1:0]] = w;
      if (model_cnt != 16'hFFFF) model_cnt = model_cnt + 16'd1;
    end else begin
      model_err = 1'b1;
    end
  endtask

  // Called at a negedge; returns at the following negedge.
  task automatic load(input logic [15:0] a, input string tag);
    d_addr = a;
    exp_q.push_back(in_rng(a) ? model_mem[a[ADDR_BITS-1:0]] : 16'h0000);
    #1;
    check_pop(tag, d_dataout);
    @(negedge clk);
  endtask

  task automatic store(input logic [15:0] a, input logic [15:0] w);
    d_addr  = a;
    d_wdata = w;
    d_we    = 1'b1;
    @(negedge clk);
    d_we = 1'b0;
    model_store(a, w);
  endtask

  // Full handshake; optionally a core store to the same word on the READ edge.
  task automatic dbg_read(input logic [ADDR_BITS-1:0] a, input logic snoop,
                          input logic [15:0] sw, input string tag);
    dbg_addr = a;
    dbg_req  = 1'b1;
    exp_q.push_back(snoop ? sw : model_mem[a]);
    @(negedge clk);
    check({15'b0, dbg_ack}, 16'h0000, 16'h0000);
    if (snoop) begin
      d_addr  = {{(16 - ADDR_BITS){1'b0}}, a};
      d_wdata = sw;
      d_we    = 1'b1;
    end
    @(negedge clk);
    if (snoop) begin
      d_we = 1'b0;
      model_store({{(16 - ADDR_BITS){1'b0}}, a}, sw);
    end
    check({tag, "_ack_n1"}, {15'b0, dbg_ack}, 16'h0000);
    @(negedge clk);
    check({tag, "_ack_n2"}, {15'b0, dbg_ack}, 16'h0001);
    check_pop({tag, "_rdata"}, dbg_rdata);
    @(negedge clk);
    check({tag, "_ack_hold"}, {15'b0, dbg_ack}, 16'h0001);
    dbg_req = 1'b0;
    @(negedge clk);
    check({tag, "_ack_drop"}, {15'b0, dbg_ack}, 16'h0000);
    @(negedge clk);
    check({tag, "_no_retrig"}, {15'b0, dbg_ack}, 16'h0000);
  endtask

  initial begin
    r_st     = 1'b1;
    d_addr   = 16'h0000;
    d_we     = 1'b0;
    d_wdata  = 16'h0000;
    dbg_req  = 1'b0;
    dbg_addr = '0;
    model_reset();

    // Reset state
    @(negedge clk);
    check("rst_ack",   {15'b0, dbg_ack},  16'h0000);
    check("rst_rdata", dbg_rdata,         16'h0000);
    check("rst_count", st_count,          16'h0000);
    check("rst_err",   {15'b0, addr_err}, 16'h0000);
    r_st = 1'b0;
    @(negedge clk);

    // 1. Whole array reads zero after reset
    for (int i = 0; i < DEPTH; i++) load(i[15:0], "t1_load");
    check("t1_count", st_count, model_cnt);
    check("t1_err", {15'b0, addr_err}, {15'b0, model_err});

    // 2. Store then load; same-cycle load still returns the old word
    d_addr  = 16'h0012;
    d_wdata = 16'hBEEF;
    d_we    = 1'b1;
    exp_q.push_back(16'h0000);
    #1;
    check_pop("t2_no_fwd", d_dataout);
    @(negedge clk);
    d_we = 1'b0;
    model_store(16'h0012, 16'hBEEF);
    load(16'h0012, "t2_load12");
    check("t2_count", st_count, 16'h0001);
    load(16'h0013, "t2_load13");

    // 3. Out-of-range store: no write, sticky error, counter unchanged
    store(16'h0100, 16'h1234);
    check("t3_err", {15'b0, addr_err}, 16'h0001);
    check("t3_count", st_count, 16'h0001);
    load(16'h0100, "t3_load100");
    load(16'h0000, "t3_load000");
    store(16'h0005, 16'hA5A5);
    check("t3_err_sticky", {15'b0, addr_err}, 16'h0001);
    check("t3_count2", st_count, model_cnt);
    load(16'h0005, "t3_load005");

    // 4. Debug read of a stored word
    dbg_read(8'h12, 1'b0, 16'h0000, "t4");

    // 5. Core store on the READ edge returns the new data
    dbg_read(8'h20, 1'b1, 16'h5555, "t5");
    check("t5_rdata_hold", dbg_rdata, 16'h5555);
    load(16'h0020, "t5_load20");

    // 6a. Reset while acknowledging aborts the handshake and clears everything
    dbg_addr = 8'h12;
    dbg_req  = 1'b1;
    repeat (3) @(negedge clk);
    check("t6_ack_pre", {15'b0, dbg_ack}, 16'h0001);
    r_st = 1'b1;
    #1;
    model_reset();
    check("t6_ack_rst",   {15'b0, dbg_ack},  16'h0000);
    check("t6_rdata_rst", dbg_rdata,         16'h0000);
    check("t6_count_rst", st_count,          16'h0000);
    check("t6_err_rst",   {15'b0, addr_err}, 16'h0000);
    dbg_req = 1'b0;
    @(negedge clk);
    r_st = 1'b0;
    @(negedge clk);
    load(16'h0012, "t6_load12");
    load(16'h0020, "t6_load20");
    load(16'h0005, "t6_load05");
    check("t6_ack_idle", {15'b0, dbg_ack}, 16'h0000);

    // 6b. Counter saturation
    for (int i = 0; i < 65535; i++) store(16'h0030, i[15:0]);
    check("t6_count_sat", st_count, 16'hFFFF);
    store(16'h0031, 16'h7777);
    check("t6_count_hold", st_count, 16'hFFFF);
    check("t6_count_model", st_count, model_cnt);
    load(16'h0031, "t6_load31");
    load(16'h0030, "t6_load30");
    check("t6_err_final", {15'b0, addr_err}, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
